// File: rtl/muldiv_unit_if.sv
// Handshake/operand bundle between the execute stage and the iterative
// RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32
);
    localparam int RW = $clog2(REG_NUM);

    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [RW-1:0]   rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [RW-1:0]   rd_out;

    // Requester side: issues ops, observes status and write-back data.
    modport master (
        output start, kill, funct3, rs1_data, rs2_data, rd_in,
        input  busy, done, result, rd_out
    );

    // Unit side: accepts ops, reports status and write-back data.
    modport slave (
        input  start, kill, funct3, rs1_data, rs2_data, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are converted to
// magnitudes on accept, XLEN shift-add (MUL*) or restoring shift-subtract
// (DIV*) iterations follow, and the sign fixup is applied as the final
// iteration retires into the DONE state.
module muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int RW = $clog2(REG_NUM);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [2:0]      r_f3;
    logic [RW-1:0]   r_rd;
    logic [XLEN-1:0] r_opnd;   // multiplicand (MUL*) or divisor (DIV*) magnitude
    logic [XLEN-1:0] r_hi;     // product high half / partial remainder
    logic [XLEN-1:0] r_lo;     // multiplier bits / dividend-then-quotient bits
    logic            r_neg_q;  // product or quotient must be negated
    logic            r_neg_r;  // remainder must be negated
    logic            r_div0;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;
    logic [RW-1:0]   r_rd_out;

    logic            w_a_sgn;
    logic            w_b_sgn;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_hi_nx;
    logic [XLEN-1:0] w_lo_nx;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0] w_quo_s;
    logic [XLEN-1:0] w_rem_s;
    logic [XLEN-1:0] w_final;

    // Two's-complement negation at operand width.
    function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation at product width.
    function automatic logic [2*XLEN-1:0] f_neg2(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Operand signedness and magnitudes for the op being offered.
    always_comb begin
        w_a_sgn = 1'b0;
        w_b_sgn = 1'b0;
        case (bus.funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_a_sgn = 1'b1;
                w_b_sgn = 1'b1;
            end
            3'b010: begin
                w_a_sgn = 1'b1;
                w_b_sgn = 1'b0;
            end
            default: begin
                w_a_sgn = 1'b0;
                w_b_sgn = 1'b0;
            end
        endcase
        w_a_neg = w_a_sgn & bus.rs1_data[XLEN-1];
        w_b_neg = w_b_sgn & bus.rs2_data[XLEN-1];
        w_a_mag = w_a_neg ? f_neg(bus.rs1_data) : bus.rs1_data;
        w_b_mag = w_b_neg ? f_neg(bus.rs2_data) : bus.rs2_data;
    end

    // One iteration step for the op in flight, and its sign-corrected result.
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, r_opnd});
        w_diff  = w_shift[XLEN-1:0] - r_opnd;
        if (r_f3[2]) begin
            w_hi_nx = w_ge ? w_diff : w_shift[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_hi_nx = w_sum[XLEN:1];
            w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
        end
        w_prod_s = r_neg_q ? f_neg2({w_hi_nx, w_lo_nx}) : {w_hi_nx, w_lo_nx};
        w_quo_s  = r_neg_q ? f_neg(w_lo_nx) : w_lo_nx;
        w_rem_s  = r_neg_r ? f_neg(w_hi_nx) : w_hi_nx;
        // Divide-by-zero quotient is forced to all ones; REM by zero already
        // yields the dividend, and the signed-overflow case yields
        // -2^(XLEN-1) / 0 naturally from the magnitude path.
        case (r_f3)
            3'b000:                 w_final = w_prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = r_div0 ? {XLEN{1'b1}} : w_quo_s;
            3'b110, 3'b111:         w_final = w_rem_s;
            default:                w_final = {XLEN{1'b0}};
        endcase
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= {CW{1'b0}};
            r_f3     <= 3'b000;
            r_rd     <= {RW{1'b0}};
            r_opnd   <= {XLEN{1'b0}};
            r_hi     <= {XLEN{1'b0}};
            r_lo     <= {XLEN{1'b0}};
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {XLEN{1'b0}};
            r_rd_out <= {RW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= S_BUSY;
                        r_busy  <= 1'b1;
                        r_count <= {CW{1'b0}};
                        r_f3    <= bus.funct3;
                        r_rd    <= bus.rd_in;
                        r_hi    <= {XLEN{1'b0}};
                        r_lo    <= bus.funct3[2] ? w_a_mag : w_b_mag;
                        r_opnd  <= bus.funct3[2] ? w_b_mag : w_a_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_div0  <= (bus.rs2_data == {XLEN{1'b0}});
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (bus.kill) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hi    <= w_hi_nx;
                        r_lo    <= w_lo_nx;
                        r_count <= r_count + CW'(1);
                        if (r_count == LAST_CNT) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_final;
                            r_rd_out <= r_rd;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.rd_out = r_rd_out;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized
// ops against a plain-arithmetic reference, and handshake corner sequences.
module tb_muldiv_unit;
    localparam int XLEN    = 32;
    localparam int REG_NUM = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(XLEN), .REG_NUM(REG_NUM)) bus();

    muldiv_unit #(.XLEN(XLEN), .REG_NUM(REG_NUM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [15];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics from 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Present an op at a negedge; returns 1ns after the accepting edge with
    // the operand lines scrambled so late latching would be visible.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic with_kill);
        bus.funct3   = f3;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd_in    = rd;
        bus.start    = 1'b1;
        bus.kill     = with_kill;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.kill     = 1'b0;
        bus.funct3   = 3'($urandom);
        bus.rs1_data = 32'($urandom);
        bus.rs2_data = 32'($urandom);
        bus.rd_in    = 5'($urandom);
    endtask

    // Wait (bounded) for done; leaves the bench at the negedge where done is seen.
    task automatic wait_done(input string name, output logic [31:0] res,
                             output logic [4:0] rd, output int lat);
        int busy_bad;
        busy_bad = 0;
        for (lat = 1; lat <= 40; lat++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) break;
            if (!bus.busy) busy_bad++;
        end
        check({name, "_done_seen"}, 32'(bus.done), 32'd1);
        check({name, "_busy_gaps"}, 32'(busy_bad), 32'd0);
        check({name, "_busy_with_done"}, 32'(bus.busy), 32'd0);
        res = bus.result;
        rd  = bus.rd_out;
    endtask

    task automatic run_vec(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        start_op(f3, a, b, rd, 1'b0);
        wait_done(name, res, rdo, lat);
        check({name, "_result"}, res, exp);
        check({name, "_rd_out"}, 32'(rdo), 32'(rd));
        check({name, "_latency"}, 32'(lat), 32'd32);
        @(negedge clk);
        check({name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic [4:0]  rdo;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          lat;
        int          done_seen;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000};
        vecs[2]  = '{3'd2, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'hC000_0000};
        vecs[3]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000};
        vecs[4]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 5'd0,  32'h0000_0000};
        vecs[5]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFD};
        vecs[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF};
        vecs[7]  = '{3'd5, 32'hFFFF_FFFF, 32'd2,         5'd7,  32'h7FFF_FFFF};
        vecs[8]  = '{3'd4, 32'd5,          32'd0,         5'd8,  32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'd5,          32'd0,         5'd9,  32'd5};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0};
        vecs[12] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         5'd31, 32'hFFFF_FFF9};
        vecs[13] = '{3'd5, 32'd0,          32'd0,         5'd12, 32'hFFFF_FFFF};
        vecs[14] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'd0};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.kill     = 1'b0;
        bus.funct3   = 3'd0;
        bus.rs1_data = 32'd0;
        bus.rs2_data = 32'd0;
        bus.rd_in    = 5'd0;
        repeat (2) @(negedge clk);
        check("reset_busy",   32'(bus.busy),   32'd0);
        check("reset_done",   32'(bus.done),   32'd0);
        check("reset_result", bus.result,      32'd0);
        check("reset_rd_out", 32'(bus.rd_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                    vecs[i].rd, vecs[i].exp);
        end

        // Randomized ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom);
            run_vec($sformatf("rand%0d_f%0d_%08h_%08h", i, f3, a, b), f3, a, b, rd,
                    ref_model(f3, a, b));
        end

        // Start pulsed mid-BUSY with different operands is ignored.
        start_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.funct3   = 3'd4;
        bus.rs1_data = 32'd100;
        bus.rs2_data = 32'd3;
        bus.rd_in    = 5'd20;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ignored_start", res, rdo, lat);
        check("ignored_start_result",  res,         32'hFFFF_FFEB);
        check("ignored_start_rd_out",  32'(rdo),    32'd9);
        check("ignored_start_latency", 32'(lat),    32'd26);
        @(negedge clk);

        // Back-to-back: new start in the DONE cycle.
        start_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b0);
        wait_done("b2b_first", res, rdo, lat);
        check("b2b_first_result", res, 32'hFFFF_FFFD);
        start_op(3'd7, 32'd100, 32'd7, 5'd4, 1'b0);
        wait_done("b2b_second", res, rdo, lat);
        check("b2b_second_result",  res,      32'd2);
        check("b2b_second_rd_out",  32'(rdo), 32'd4);
        check("b2b_second_latency", 32'(lat), 32'd32);
        @(negedge clk);

        // Kill together with start in IDLE: start wins.
        start_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b1);
        wait_done("kill_start", res, rdo, lat);
        check("kill_start_result",  res,      32'hFFFF_FFFE);
        check("kill_start_latency", 32'(lat), 32'd32);
        @(negedge clk);

        // Kill at count 10: back to IDLE, no done, outputs untouched.
        start_op(3'd5, 32'd1000, 32'd10, 5'd6, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        @(negedge clk);
        check("kill_busy_dropped", 32'(bus.busy), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("kill_no_done",   32'(done_seen),  32'd0);
        check("kill_result",    bus.result,      32'hFFFF_FFFE);
        check("kill_rd_out",    32'(bus.rd_out), 32'd5);

        // Asynchronous reset mid-op clears outputs immediately.
        start_op(3'd0, 32'd3, 32'd5, 5'd7, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("areset_busy",   32'(bus.busy),   32'd0);
        check("areset_done",   32'(bus.done),   32'd0);
        check("areset_result", bus.result,      32'd0);
        check("areset_rd_out", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_vec("after_reset", 3'd0, 32'd3, 32'd5, 5'd7, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
